// File: rtl/nn_eval_sequencer_pkg.sv
// Shared sizing constants, weight-count macros and state encodings for the threshold-net evaluator.
// Override NN_DATA_WIDTH / NN_INPUT_SIZE / NN_HIDDEN_SIZE / NN_OUTPUT_SIZE on the command line to resize.
`ifndef NN_DATA_WIDTH
`define NN_DATA_WIDTH 16
`endif
`ifndef NN_INPUT_SIZE
`define NN_INPUT_SIZE 2
`endif
`ifndef NN_HIDDEN_SIZE
`define NN_HIDDEN_SIZE 2
`endif
`ifndef NN_OUTPUT_SIZE
`define NN_OUTPUT_SIZE 1
`endif
`ifndef NN_GET_WEIGHTS_SIZE_1
`define NN_GET_WEIGHTS_SIZE_1(i, h) ((h) * ((i) + 1))
`endif
`ifndef NN_GET_WEIGHTS_SIZE
`define NN_GET_WEIGHTS_SIZE(i, h, o) (`NN_GET_WEIGHTS_SIZE_1(i, h) + (o) * ((h) + 1))
`endif

package nn_eval_sequencer_pkg;
   localparam int NN_W = `NN_DATA_WIDTH;
   localparam int NN_I = `NN_INPUT_SIZE;
   localparam int NN_H = `NN_HIDDEN_SIZE;
   localparam int NN_O = `NN_OUTPUT_SIZE;
   localparam logic [NN_W-1:0] NN_ONE = NN_W'(1) << (NN_W / 2);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } seq_state_t;

   function automatic int n_weights(input int i, input int h, input int o);
      return `NN_GET_WEIGHTS_SIZE(i, h, o);
   endfunction

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction
endpackage

// File: rtl/nn_eval_sequencer_if.sv
// Evaluator bus: start/busy/done handshake, weight memory read port and results.
// raw_sum_data exists only when NN_SEQ_RAW_OUT_EN is defined.
interface nn_eval_sequencer_if
   import nn_eval_sequencer_pkg::*;
#(
   parameter int DATA_WIDTH  = NN_W,
   parameter int INPUT_SIZE  = NN_I,
   parameter int OUTPUT_SIZE = NN_O,
   parameter int ADDR_WIDTH  = 8
);
   logic                              start;
   logic [DATA_WIDTH*INPUT_SIZE-1:0]  input_data;
   logic                              busy;
   logic                              done;
   logic                              weight_rd_en;
   logic [ADDR_WIDTH-1:0]             weight_addr;
   logic [DATA_WIDTH-1:0]             weight_rd_data;
   logic [DATA_WIDTH*OUTPUT_SIZE-1:0] output_data;
`ifdef NN_SEQ_RAW_OUT_EN
   logic [DATA_WIDTH*OUTPUT_SIZE-1:0] raw_sum_data;

   modport master (output start, input_data, weight_rd_data,
                   input  busy, done, weight_rd_en, weight_addr, output_data, raw_sum_data);
   modport slave  (input  start, input_data, weight_rd_data,
                   output busy, done, weight_rd_en, weight_addr, output_data, raw_sum_data);
`else
   modport master (output start, input_data, weight_rd_data,
                   input  busy, done, weight_rd_en, weight_addr, output_data);
   modport slave  (input  start, input_data, weight_rd_data,
                   output busy, done, weight_rd_en, weight_addr, output_data);
`endif
endinterface

// File: rtl/nn_mac_unit.sv
// Fixed-point MAC: acc <= acc + ((x*w) >> W/2) truncated to W bits; clear wins over accumulate.
// One-cycle update; ge compares the held accumulator against w as an unsigned threshold.
module nn_mac_unit #(
   parameter int DATA_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  clr,
   input  logic                  acc_en,
   input  logic [DATA_WIDTH-1:0] x,
   input  logic [DATA_WIDTH-1:0] w,
   output logic [DATA_WIDTH-1:0] acc,
   output logic                  ge
);
   logic [2*DATA_WIDTH-1:0] prod;
   logic [DATA_WIDTH-1:0]   term;

   always_comb begin
      prod = (2*DATA_WIDTH)'(x) * (2*DATA_WIDTH)'(w);
      term = DATA_WIDTH'(prod >> (DATA_WIDTH / 2));
      ge   = (acc >= w);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)
         acc <= '0;
      else if (clr)
         acc <= '0;
      else if (acc_en)
         acc <= acc + term;
   end
endmodule

// File: rtl/nn_eval_sequencer.sv
// Time-multiplexed 2-layer threshold-net evaluator streaming weights from a 1-cycle-latency memory.
// done pulses N_W+2 cycles after accept; start ignored while busy. NN_SEQ_RAW_OUT_EN adds raw_sum_data.
module nn_eval_sequencer
   import nn_eval_sequencer_pkg::*;
#(
   parameter int DATA_WIDTH  = NN_W,
   parameter int INPUT_SIZE  = NN_I,
   parameter int HIDDEN_SIZE = NN_H,
   parameter int OUTPUT_SIZE = NN_O,
   parameter int ADDR_WIDTH  = 8
) (
   input logic                clk,
   input logic                resetn,
   nn_eval_sequencer_if.slave bus
);
   localparam int N_W   = n_weights(INPUT_SIZE, HIDDEN_SIZE, OUTPUT_SIZE);
   localparam int IDX_W = $clog2(max2(INPUT_SIZE, HIDDEN_SIZE) + 1);
   localparam int NRN_W = $clog2(max2(HIDDEN_SIZE, OUTPUT_SIZE) + 1);
   localparam logic [DATA_WIDTH-1:0] ONE = DATA_WIDTH'(1) << (DATA_WIDTH / 2);

   seq_state_t               state_q, state_d;
   logic                     accept, last_addr, rd_vld_q, done_q;
   logic [ADDR_WIDTH-1:0]    addr_q;
   logic                     layer_q;
   logic [NRN_W-1:0]         nrn_q;
   logic [IDX_W-1:0]         idx_q, fan_in;
   logic                     is_thr, last_nrn, ge;
   logic [DATA_WIDTH-1:0]    x_sel, acc;
   logic [DATA_WIDTH-1:0]    in_q  [INPUT_SIZE];
   logic [DATA_WIDTH-1:0]    out_q [OUTPUT_SIZE];
   logic [HIDDEN_SIZE-1:0]   hid_q;

   always_comb begin
      state_d          = state_q;
      accept           = 1'b0;
      last_addr        = (addr_q == ADDR_WIDTH'(N_W - 1));
      bus.busy         = (state_q != ST_IDLE);
      bus.weight_rd_en = (state_q == ST_RUN);
      bus.weight_addr  = addr_q;
      bus.done         = done_q;
      case (state_q)
         ST_IDLE: if (bus.start) begin
            accept  = 1'b1;
            state_d = ST_RUN;
         end
         ST_RUN:   if (last_addr) state_d = ST_DRAIN;
         ST_DRAIN: state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state_q <= ST_IDLE;
      else         state_q <= state_d;
   end

   // Read data trails the strobe by one cycle, so rd_vld_q marks which cycles carry a word.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         addr_q   <= '0;
         rd_vld_q <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         rd_vld_q <= (state_q == ST_RUN);
         done_q   <= (state_q == ST_DRAIN);
         if (accept)
            addr_q <= '0;
         else if (state_q == ST_RUN)
            addr_q <= last_addr ? '0 : addr_q + 1'b1;
      end
   end

   always_comb begin
      fan_in   = layer_q ? IDX_W'(HIDDEN_SIZE) : IDX_W'(INPUT_SIZE);
      last_nrn = (nrn_q == (layer_q ? NRN_W'(OUTPUT_SIZE - 1) : NRN_W'(HIDDEN_SIZE - 1)));
      is_thr   = rd_vld_q && (idx_q == fan_in);
      // A hidden bit is fed as 1.0 so the MAC passes the weight through unchanged.
      x_sel    = '0;
      for (int i = 0; i < INPUT_SIZE; i++)
         if (!layer_q && idx_q == IDX_W'(i)) x_sel = in_q[i];
      for (int j = 0; j < HIDDEN_SIZE; j++)
         if (layer_q && idx_q == IDX_W'(j) && hid_q[j]) x_sel = ONE;
   end

   nn_mac_unit #(.DATA_WIDTH(DATA_WIDTH)) u_mac (
      .clk    (clk),
      .resetn (resetn),
      .clr    (accept || is_thr),
      .acc_en (rd_vld_q && !is_thr),
      .x      (x_sel),
      .w      (bus.weight_rd_data),
      .acc    (acc),
      .ge     (ge)
   );

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         layer_q <= 1'b0;
         nrn_q   <= '0;
         idx_q   <= '0;
      end else if (accept) begin
         layer_q <= 1'b0;
         nrn_q   <= '0;
         idx_q   <= '0;
      end else if (rd_vld_q) begin
         if (is_thr) begin
            idx_q <= '0;
            if (last_nrn) begin
               layer_q <= !layer_q;
               nrn_q   <= '0;
            end else begin
               nrn_q <= nrn_q + 1'b1;
            end
         end else begin
            idx_q <= idx_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < INPUT_SIZE; i++) in_q[i] <= '0;
      end else if (accept) begin
         for (int i = 0; i < INPUT_SIZE; i++) in_q[i] <= bus.input_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         hid_q <= '0;
         for (int k = 0; k < OUTPUT_SIZE; k++) out_q[k] <= '0;
      end else if (is_thr) begin
         for (int j = 0; j < HIDDEN_SIZE; j++)
            if (!layer_q && nrn_q == NRN_W'(j)) hid_q[j] <= ge;
         for (int k = 0; k < OUTPUT_SIZE; k++)
            if (layer_q && nrn_q == NRN_W'(k)) out_q[k] <= ge ? ONE : '0;
      end
   end

   always_comb begin
      bus.output_data = '0;
      for (int k = 0; k < OUTPUT_SIZE; k++)
         bus.output_data[k*DATA_WIDTH +: DATA_WIDTH] = out_q[k];
   end

`ifdef NN_SEQ_RAW_OUT_EN
   logic [DATA_WIDTH-1:0] raw_q [OUTPUT_SIZE];

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int k = 0; k < OUTPUT_SIZE; k++) raw_q[k] <= '0;
      end else if (is_thr) begin
         for (int k = 0; k < OUTPUT_SIZE; k++)
            if (layer_q && nrn_q == NRN_W'(k)) raw_q[k] <= acc;
      end
   end

   always_comb begin
      bus.raw_sum_data = '0;
      for (int k = 0; k < OUTPUT_SIZE; k++)
         bus.raw_sum_data[k*DATA_WIDTH +: DATA_WIDTH] = raw_q[k];
   end
`endif
endmodule
